// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: gates the PC and pipeline-register enables.
// Inserts bubbles and flushes for load-use hazards, taken branches and
// data-memory wait states. Also keeps a saturating stall counter and a
// sticky memory-timeout flag.
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             timeout_err
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  // Control bundle order: {pc, ifid, flush, idex, bubble, exmem}
  localparam logic [5:0] CTL_HOLD   = 6'b000000;
  localparam logic [5:0] CTL_SQUASH = 6'b111111;
  localparam logic [5:0] CTL_LDUSE  = 6'b000111;
  localparam logic [5:0] CTL_GO     = 6'b110101;
  localparam logic [7:0] TMO        = 8'(TIMEOUT);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       err_set;
  logic       mem_stall, load_use, ms_eff;
  logic [5:0] nrm, ctl, ctl_q;
  logic       cnt_inc;

  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use  = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  // In the MEM_WAIT release cycle the memory stall is treated as resolved.
  assign ms_eff    = (state == RUN) & mem_stall;

  // Normal evaluation: mem stall beats branch, which beats load-use.
  always_comb begin
    nrm = CTL_GO;
    if (ms_eff)               nrm = CTL_HOLD;
    else if (ex_branch_taken) nrm = CTL_SQUASH;
    else if (load_use)        nrm = CTL_LDUSE;
  end

  // Next-state, wait counter and control selection per state.
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    err_set  = 1'b0;
    ctl      = CTL_HOLD;
    case (state)
      RUN: begin
        ctl = nrm;
        if (mem_stall) begin
          state_nx = MEM_WAIT;
          wait_nx  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ctl      = nrm;
          state_nx = RUN;
          wait_nx  = 8'd0;
        end else if (wait_cnt < TMO) begin
          wait_nx = wait_cnt + 8'd1;
        end else begin
          state_nx = ERROR;
          err_set  = 1'b1;
        end
      end
      ERROR:   ctl = CTL_HOLD;
      default: state_nx = RUN;
    endcase
  end

  // Reset forces every enable and flush/bubble low, independent of the clock.
  assign ctl_q = reset_n ? ctl : CTL_HOLD;
  assign {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write} = ctl_q;

  // The edge that enters ERROR is not counted; the counter freezes from there on.
  assign cnt_inc = ~ctl[5] & (state != ERROR) & (state_nx != ERROR);

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      stall_cycles <= '0;
    else if (cnt_inc && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     timeout_err <= 1'b0;
    else if (err_set) timeout_err <= 1'b1;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, hand sequences for
// multi-cycle corners, and random stimulus against a behavioural model.
module tb_hazard_stall_ctrl;
  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic clk, reset_n;
  logic id_valid, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, dmem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
  logic [CW-1:0] stall_cycles;
  logic timeout_err;
  logic [5:0] outs;

  int n_cmp = 0, n_bad = 0;
  int m_w = 0;        // consecutive memory wait cycles so far (0: not waiting)
  bit m_err = 0;
  int m_st = 0;

  hazard_stall_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_bubble(idex_bubble),
    .exmem_write(exmem_write), .stall_cycles(stall_cycles), .timeout_err(timeout_err));

  assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic v; logic [4:0] r1, r2; logic u2, mr; logic [4:0] rd;
    logic br, mq, rdy; logic [5:0] exp;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setin(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u2, input logic mr, input logic [4:0] rd,
                       input logic br, input logic mq, input logic rdy);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2; ex_mem_read = mr;
    ex_rd = rd; ex_branch_taken = br; mem_req = mq; dmem_ready = rdy;
  endtask

  // Moves to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_w = 0; m_err = 0; m_st = 0;
    tick();
    reset_n = 1;
  endtask

  // Reference: which control bundle the spec's rules give for the current inputs.
  function automatic logic [5:0] exp_out();
    bit hit, ms;
    if (!reset_n || m_err) return 6'b000000;
    hit = id_valid && ex_mem_read && ex_rd != 0 &&
          (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    ms = (m_w == 0) && mem_req && !dmem_ready;
    if (m_w > 0 && !dmem_ready) return 6'b000000;
    if (ms)              return 6'b000000;
    if (ex_branch_taken) return 6'b111111;
    if (hit)             return 6'b000111;
    return 6'b110101;
  endfunction

  // Advances the model across one rising edge for the current inputs.
  task automatic model_edge();
    logic [5:0] o;
    bit to_err;
    o = exp_out();
    to_err = 0;
    if (m_err) return;
    if (m_w > 0) begin
      if (dmem_ready) m_w = 0;
      else if (m_w == TMO) begin to_err = 1; m_err = 1; m_w = 0; end
      else m_w++;
    end else if (mem_req && !dmem_ready) m_w = 1;
    if (!o[5] && !to_err) m_st = (m_st + 1 > SMAX) ? SMAX : m_st + 1;
  endtask

  initial begin
    reset_n = 0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110101};
    tbl[1]  = '{1, 5, 0, 0, 1, 5, 0, 0, 0, 6'b000111};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 6'b110101};
    tbl[3]  = '{1, 1, 7, 0, 1, 7, 0, 0, 0, 6'b110101};
    tbl[4]  = '{1, 1, 7, 1, 1, 7, 0, 0, 0, 6'b000111};
    tbl[5]  = '{0, 5, 0, 0, 1, 5, 0, 0, 0, 6'b110101};
    tbl[6]  = '{1, 5, 0, 0, 0, 5, 0, 0, 0, 6'b110101};
    tbl[7]  = '{1, 5, 0, 0, 1, 5, 1, 0, 0, 6'b111111};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111111};
    tbl[9]  = '{1, 3, 0, 0, 1, 3, 0, 1, 1, 6'b000111};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b110101};

    // Reset state
    #3;
    chk("reset_outs", 32'(outs), 0);
    chk("reset_cnt", 32'(stall_cycles), 0);
    chk("reset_err", 32'(timeout_err), 0);
    tick(); tick();
    reset_n = 1;

    // Vector table, all applied in RUN
    foreach (tbl[i]) begin
      setin(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].u2, tbl[i].mr, tbl[i].rd,
            tbl[i].br, tbl[i].mq, tbl[i].rdy);
      #3;
      chk($sformatf("tbl%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
      tick();
    end
    chk("tbl_cnt", 32'(stall_cycles), 3);

    // Load-use: one stalled cycle, counter 0->1; ex_rd=0 never stalls
    do_reset();
    setin(1, 5, 0, 0, 1, 5, 0, 0, 0); #3;
    chk("lu_outs", 32'(outs), 32'(6'b000111));
    tick();
    chk("lu_cnt", 32'(stall_cycles), 1);
    setin(1, 0, 0, 0, 1, 0, 0, 0, 0); #3;
    chk("lu_x0_outs", 32'(outs), 32'(6'b110101));
    tick();
    chk("lu_x0_cnt", 32'(stall_cycles), 1);

    // Branch beats load-use, counter unchanged
    setin(1, 5, 0, 0, 1, 5, 1, 0, 0); #3;
    chk("br_lu_outs", 32'(outs), 32'(6'b111111));
    tick();
    chk("br_lu_cnt", 32'(stall_cycles), 1);

    // Memory wait: 3 wait cycles, release on the 4th
    do_reset();
    for (int k = 0; k < 3; k++) begin
      setin(0, 0, 0, 0, 0, 0, 0, 1, 0); #3;
      chk($sformatf("mw_hold%0d", k), 32'(outs), 0);
      tick();
    end
    setin(0, 0, 0, 0, 0, 0, 1, 1, 1); #3;
    chk("mw_release_br", 32'(outs), 32'(6'b111111));
    tick();
    chk("mw_cnt", 32'(stall_cycles), 3);
    setin(0, 0, 0, 0, 0, 0, 0, 1, 0); #3;
    chk("mw_back_run", 32'(outs), 0);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("mw_run_go", 32'(outs), 32'(6'b110101));
    tick();
    chk("mw_cnt2", 32'(stall_cycles), 3);

    // Timeout into ERROR, then async reset mid-cycle
    do_reset();
    setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("to_hold%0d", k), 32'(outs), 0);
      chk($sformatf("to_err_pre%0d", k), 32'(timeout_err), 0);
      tick();
    end
    chk("to_err", 32'(timeout_err), 1);
    setin(1, 0, 0, 0, 0, 0, 0, 1, 1);
    tick(); tick(); #2;
    chk("err_outs", 32'(outs), 0);
    chk("err_sticky", 32'(timeout_err), 1);
    chk("err_cnt", 32'(stall_cycles), 4);
    reset_n = 0; #1;
    chk("arst_err", 32'(timeout_err), 0);
    chk("arst_outs", 32'(outs), 0);
    chk("arst_cnt", 32'(stall_cycles), 0);
    tick();
    reset_n = 1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("arst_run", 32'(outs), 32'(6'b110101));

    // Counter saturation
    do_reset();
    setin(1, 9, 0, 0, 1, 9, 0, 0, 0);
    for (int k = 0; k < 20; k++) tick();
    chk("sat_cnt", 32'(stall_cycles), SMAX);
    chk("sat_outs", 32'(outs), 32'(6'b000111));

    // Random stimulus against the model, reset between chunks
    for (int c = 0; c < 12; c++) begin
      do_reset();
      for (int k = 0; k < 60; k++) begin
        setin(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) < 7));
        if (m_w > 0) mem_req = 1;
        #3;
        chk("rnd_outs", 32'(outs), 32'(exp_out()));
        model_edge();
        tick();
        chk("rnd_cnt", 32'(stall_cycles), 32'(m_st));
        chk("rnd_err", 32'(timeout_err), 32'(m_err));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
